// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared field constants, scheduler states and operand screen
package ecc_pkg;

  localparam int FIELD_W = 256;

  // secp256k1 field prime: 2^256 - 2^32 - 977
  localparam logic [FIELD_W-1:0] P_SECP256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  // zero and out-of-field operands have no inverse and would stall the engine
  function automatic logic operand_ok(input logic [FIELD_W-1:0] a);
    return (a != '0) && (a < P_SECP256K1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotate-priority one-hot arbiter, search starts at ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  int idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mod_inv_sched.sv
// rtl/mod_inv_sched.sv - round-robin share of one mod_inv engine with operand screen and watchdog
module mod_inv_sched
  import ecc_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT     = 65536,
  parameter int RECOVER_CYC = 2,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*FIELD_W-1:0] req_a,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [FIELD_W-1:0]       rsp_result,
  output logic                     rsp_err,
  output logic                     eng_start,
  output logic [FIELD_W-1:0]       eng_a,
  output logic                     eng_rst,
  input  logic [FIELD_W-1:0]       eng_result,
  input  logic                     eng_done,
  output logic                     busy,
  output logic [IW-1:0]            grant_id
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam int RC_W = $clog2(RECOVER_CYC + 1);

  state_t             state, nxt;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IW-1:0]      arb_id;
  logic               arb_any;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [FIELD_W-1:0] grant_a;
  logic [FIELD_W-1:0] op_q;
  logic [FIELD_W-1:0] res_q;
  logic               err_q;
  logic               tmo_q;
  logic               rec_arm;
  logic [WD_W-1:0]    wd;
  logic [RC_W-1:0]    rec_cnt;
  logic               wd_hit;
  logic               rec_last;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    grant_a = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_id == IW'(i)) grant_a = req_a[i*FIELD_W +: FIELD_W];
  end

  assign wd_hit   = (wd == WD_W'(TIMEOUT - 1));
  assign rec_last = (rec_cnt <= RC_W'(1));

  // rec_arm makes the first IDLE after reset count as an engine-reset cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rec_arm <= 1'b1;
      wd      <= '0;
      rec_cnt <= RC_W'(RECOVER_CYC);
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (rec_arm) begin
            rec_arm <= 1'b0;
            rec_cnt <= rec_cnt - 1'b1;
          end else if (arb_any) begin
            owner  <= arb_id;
            op_q   <= grant_a;
            rr_ptr <= (arb_id == IW'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
          end
        end
        CHECK: begin
          tmo_q <= 1'b0;
          if (!operand_ok(op_q)) begin
            err_q <= 1'b1;
            res_q <= '0;
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          wd <= wd + 1'b1;
          if (eng_done) begin
            res_q <= eng_result;
            err_q <= 1'b0;
          end else if (wd_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
            tmo_q <= 1'b1;
          end
        end
        RESP: begin
          tmo_q <= 1'b0;
          if (tmo_q) rec_cnt <= RC_W'(RECOVER_CYC);
        end
        RECOVER: rec_cnt <= rec_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt        = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_err    = 1'b0;
    eng_start  = 1'b0;
    eng_rst    = 1'b0;
    case (state)
      IDLE: begin
        if (rec_arm) begin
          eng_rst = 1'b1;
          nxt     = rec_last ? IDLE : RECOVER;
        end else if (arb_any) begin
          req_ready = arb_gnt;
          nxt       = CHECK;
        end
      end
      CHECK: nxt = operand_ok(op_q) ? ISSUE : RESP;
      ISSUE: begin
        eng_start = 1'b1;
        nxt       = WAIT;
      end
      // done is checked first so a same-cycle done beats the watchdog
      WAIT: begin
        if (eng_done || wd_hit) nxt = RESP;
      end
      RESP: begin
        rsp_valid  = N_REQ'(1) << owner;
        rsp_result = err_q ? '0 : res_q;
        rsp_err    = err_q;
        nxt        = tmo_q ? RECOVER : IDLE;
      end
      RECOVER: begin
        eng_rst = 1'b1;
        if (rec_last) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign eng_a    = op_q;
  assign grant_id = owner;

endmodule

// File: tb/tb_mod_inv_sched.sv
// tb/tb_mod_inv_sched.sv - directed self-checking bench for mod_inv_sched with a latency-programmable engine model
module tb_mod_inv_sched;

  localparam int N = 4;
  localparam logic [255:0] TB_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*256-1:0] req_a = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [255:0]     rsp_result;
  logic             rsp_err;
  logic             eng_start;
  logic [255:0]     eng_a;
  logic             eng_rst;
  logic [255:0]     eng_result = '0;
  logic             eng_done = 1'b0;
  logic             busy;
  logic [1:0]       grant_id;

  int passed = 0, total = 0, fails = 0;
  int cyc = 0, starts = 0, pulses = 0, lat = 1, cnt = 0;
  logic [255:0] model_res = '0;

  logic [N-1:0] rdy, v;
  logic [255:0] r;
  logic         e;
  int           g, t, dly, s0, p0;

  always #5 clk = ~clk;

  mod_inv_sched #(
    .N_REQ       (N),
    .TIMEOUT     (16),
    .RECOVER_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_rst    (eng_rst),
    .eng_result (eng_result),
    .eng_done   (eng_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // engine: done is a level that drops on start; lat = 0 means it never finishes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|rsp_valid) pulses <= pulses + 1;
    if (eng_start) starts <= starts + 1;
    if (eng_rst) begin
      eng_done <= 1'b0;
      cnt      <= 0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      cnt      <= lat;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        eng_done   <= 1'b1;
        eng_result <= model_res;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // call right after driving at a negedge: the grant can land in that same cycle
  task automatic wait_ready(output logic [N-1:0] rd, output int at);
    logic found;
    found = 1'b0;
    rd = '0;
    at = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      #1;
      if (req_ready != '0) begin
        found = 1'b1;
        rd = req_ready;
        at = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check("grant_timeout", 256'd0, 256'd1);
  endtask

  task automatic wait_rsp(output logic [N-1:0] vv, output logic [255:0] rr, output logic ee, output int at);
    logic found;
    found = 1'b0;
    vv = '0;
    rr = '0;
    ee = 1'b0;
    at = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0) begin
        found = 1'b1;
        vv = rsp_valid;
        rr = rsp_result;
        ee = rsp_err;
        at = cyc;
      end
    end
    if (!found) check("rsp_timeout", 256'd0, 256'd1);
  endtask

  task automatic run_op(input int idx, input logic [255:0] a, input int l, input logic [255:0] res,
                        output logic [N-1:0] rd, output logic [N-1:0] vv, output logic [255:0] rr,
                        output logic ee, output int d);
    int gg, tt;
    @(negedge clk);
    req_a[idx*256 +: 256] = a;
    req_valid[idx] = 1'b1;
    lat = l;
    model_res = res;
    wait_ready(rd, gg);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    wait_rsp(vv, rr, ee, tt);
    d = tt - gg;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    // reset state, with a request already pending
    rst_n = 1'b0;
    req_valid = 4'b0001;
    req_a[255:0] = 256'd1;
    lat = 1;
    model_res = 256'd1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_rst", eng_rst, 1);
    check("rst_grant_id", grant_id, 0);
    check("rst_eng_a", eng_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_eng_rst", eng_rst, 1);
    check("rel_req_ready", req_ready, 0);
    @(negedge clk);
    #1;
    check("rec_eng_rst", eng_rst, 1);
    check("rec_busy", busy, 1);

    // single op, a=1, done one cycle after start
    @(negedge clk);
    s0 = starts;
    wait_ready(rdy, g);
    check("t1_ready", rdy, 4'b0001);
    check("t1_eng_rst_low", eng_rst, 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t1_check_busy", busy, 1);
    check("t1_check_no_start", eng_start, 0);
    @(negedge clk);
    #1;
    check("t1_issue_start", eng_start, 1);
    check("t1_issue_eng_a", eng_a, 256'd1);
    wait_rsp(v, r, e, t);
    check("t1_rsp_valid", v, 4'b0001);
    check("t1_rsp_result", r, 256'd1);
    check("t1_rsp_err", e, 0);
    check("t1_latency", t - g, 5);
    check("t1_starts", starts - s0, 1);

    // round robin: req1 and req3 together, req1 held for a second op
    @(negedge clk);
    req_valid = 4'b1010;
    req_a[256 +: 256] = 256'd5;
    req_a[768 +: 256] = 256'd7;
    model_res = 256'hA1;
    wait_ready(rdy, g);
    check("t2_first_grant", rdy, 4'b0010);
    @(negedge clk);
    req_a[256 +: 256] = 256'd9;
    #1;
    check("t2_owner1", grant_id, 1);
    wait_rsp(v, r, e, t);
    check("t2_rsp1_valid", v, 4'b0010);
    check("t2_rsp1_result", r, 256'hA1);
    model_res = 256'hB3;
    wait_ready(rdy, g);
    check("t2_second_grant", rdy, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check("t2_owner3", grant_id, 3);
    check("t2_eng_a3", eng_a, 256'd7);
    wait_rsp(v, r, e, t);
    check("t2_rsp3_valid", v, 4'b1000);
    check("t2_rsp3_result", r, 256'hB3);
    model_res = 256'hC1;
    wait_ready(rdy, g);
    check("t2_third_grant", rdy, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(v, r, e, t);
    check("t2_rsp1b_valid", v, 4'b0010);
    check("t2_rsp1b_result", r, 256'hC1);
    check("t2_rsp1b_eng_a", eng_a, 256'd9);

    // operand screen: 0 and P rejected without the engine, P-1 accepted
    s0 = starts;
    run_op(2, 256'd0, 1, 256'h55, rdy, v, r, e, dly);
    check("t3_zero_valid", v, 4'b0100);
    check("t3_zero_err", e, 1);
    check("t3_zero_result", r, 0);
    check("t3_zero_latency", dly, 2);
    run_op(2, TB_P, 1, 256'h55, rdy, v, r, e, dly);
    check("t3_p_valid", v, 4'b0100);
    check("t3_p_err", e, 1);
    check("t3_p_result", r, 0);
    check("t3_no_start", starts - s0, 0);
    run_op(2, TB_P - 256'd1, 1, 256'h77, rdy, v, r, e, dly);
    check("t3_pm1_err", e, 0);
    check("t3_pm1_result", r, 256'h77);
    check("t3_pm1_start", starts - s0, 1);

    // watchdog: engine never finishes, 16 WAIT cycles then error and recovery
    s0 = starts;
    run_op(0, 256'd3, 0, 256'hDEAD, rdy, v, r, e, dly);
    check("t4_valid", v, 4'b0001);
    check("t4_err", e, 1);
    check("t4_result", r, 0);
    check("t4_latency", dly, 19);
    check("t4_start", starts - s0, 1);
    @(negedge clk);
    #1;
    check("t4_rec1", eng_rst, 1);
    @(negedge clk);
    #1;
    check("t4_rec2", eng_rst, 1);
    @(negedge clk);
    #1;
    check("t4_rec_end", eng_rst, 0);
    check("t4_idle", busy, 0);
    run_op(0, 256'd4, 1, 256'h44, rdy, v, r, e, dly);
    check("t4_next_err", e, 0);
    check("t4_next_result", r, 256'h44);
    check("t4_next_latency", dly, 5);

    // stale done still high from the last op must be ignored
    run_op(1, 256'd6, 3, 256'h66, rdy, v, r, e, dly);
    check("t5_valid", v, 4'b0010);
    check("t5_err", e, 0);
    check("t5_result", r, 256'h66);
    check("t5_latency", dly, 7);

    // async reset during WAIT aborts silently
    @(negedge clk);
    req_a[768 +: 256] = 256'd8;
    req_valid = 4'b1000;
    lat = 0;
    wait_ready(rdy, g);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_err", rsp_err, 0);
    check("t6_rsp_result", rsp_result, 0);
    check("t6_eng_start", eng_start, 0);
    check("t6_eng_a", eng_a, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_eng_rst", eng_rst, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_rel_eng_rst", eng_rst, 1);
    @(negedge clk);
    #1;
    check("t6_rec_eng_rst", eng_rst, 1);
    @(negedge clk);
    #1;
    check("t6_rec_end", eng_rst, 0);
    check("t6_idle", busy, 0);
    check("t6_no_rsp", pulses - p0, 0);
    run_op(2, 256'd2, 1, 256'h22, rdy, v, r, e, dly);
    check("t6_after_valid", v, 4'b0100);
    check("t6_after_result", r, 256'h22);
    check("t6_after_err", e, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
